memory_stage: RTL

MEMORY_STAGE -- requirements
Module: memory_stage

---
 rtl/memory_stage.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/memory_stage.sv
// Memory stage: scalar/vector load-store sequencing against a single-port 32-bit data memory.
// Vector accesses issue four word beats at base+4k; results leave as a one-cycle writeback bundle.
module memory_stage (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   input  logic [31:0]  ALUresult,
   input  logic [31:0]  WriteData,
   input  logic [127:0] VALUresult,
   input  logic         MemRead,
   input  logic         MemWrite,
   input  logic         VecMem,
   input  logic         RegWrite,
   input  logic         VRegWrite,
   input  logic [3:0]   Rd,
   output logic [31:0]  mem_addr,
   output logic [31:0]  mem_wdata,
   output logic         mem_we,
   output logic         mem_re,
   input  logic [31:0]  mem_rdata,
   output logic         stall,
   output logic         wb_valid,
   output logic [31:0]  wb_result,
   output logic [127:0] wb_vresult,
   output logic [3:0]   wb_rd,
   output logic         wb_regwrite,
   output logic         wb_vregwrite
);

   typedef enum logic [1:0] {IDLE, SLOAD, VBEAT, VLAST} state_t;

   state_t        state, next_state;
   logic [1:0]    beat;
   logic [1:0]    issue_beat;
   logic [31:0]   alu_q, wdata_q, lane_q;
   logic [127:0]  valu_q;
   logic          mr_q, mw_q, vm_q, rw_q, vrw_q;
   logic [3:0]    rd_q;
   logic [95:0]   vbuf;

   logic          done, live;
   logic [31:0]   res_n;
   logic [127:0]  vres_n;

   assign stall = (state != IDLE);

   // beat counts completed post-accept cycles; beat 0 went out from the live inputs
   assign issue_beat = beat + 2'd1;

   always_comb begin
      case (issue_beat)
         2'd1:    lane_q = valu_q[63:32];
         2'd2:    lane_q = valu_q[95:64];
         2'd3:    lane_q = valu_q[127:96];
         default: lane_q = valu_q[31:0];
      endcase
   end

   always_comb begin
      next_state = state;
      mem_addr   = alu_q;
      mem_wdata  = wdata_q;
      mem_we     = 1'b0;
      mem_re     = 1'b0;
      done       = 1'b0;
      live       = 1'b0;
      res_n      = alu_q;
      vres_n     = valu_q;
      case (state)
         IDLE: begin
            if (in_valid) begin
               mem_addr  = ALUresult;
               mem_wdata = VecMem ? VALUresult[31:0] : WriteData;
               mem_re    = MemRead;
               mem_we    = MemWrite & ~MemRead;
               if (VecMem && (MemRead || MemWrite)) begin
                  next_state = VBEAT;
               end else if (MemRead) begin
                  next_state = SLOAD;
               end else begin
                  done   = 1'b1;
                  live   = 1'b1;
                  res_n  = ALUresult;
                  vres_n = VALUresult;
               end
            end
         end
         SLOAD: begin
            next_state = IDLE;
            done       = 1'b1;
            res_n      = mem_rdata;
         end
         VBEAT: begin
            mem_addr  = alu_q + {28'd0, issue_beat, 2'b00};
            mem_wdata = vm_q ? lane_q : wdata_q;
            mem_re    = mr_q;
            mem_we    = mw_q & ~mr_q;
            if (beat == 2'd2) begin
               if (mr_q) begin
                  next_state = VLAST;
               end else begin
                  next_state = IDLE;
                  done       = 1'b1;
               end
            end
         end
         VLAST: begin
            next_state = IDLE;
            done       = 1'b1;
            vres_n     = {mem_rdata, vbuf};
         end
         default: next_state = IDLE;
      endcase
      if (!rst_n) begin
         mem_we = 1'b0;
         mem_re = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         beat         <= '0;
         alu_q        <= '0;
         wdata_q      <= '0;
         valu_q       <= '0;
         mr_q         <= 1'b0;
         mw_q         <= 1'b0;
         vm_q         <= 1'b0;
         rw_q         <= 1'b0;
         vrw_q        <= 1'b0;
         rd_q         <= '0;
         vbuf         <= '0;
         wb_valid     <= 1'b0;
         wb_result    <= '0;
         wb_vresult   <= '0;
         wb_rd        <= '0;
         wb_regwrite  <= 1'b0;
         wb_vregwrite <= 1'b0;
      end else begin
         state    <= next_state;
         wb_valid <= done;
         if (state == IDLE && in_valid) begin
            alu_q   <= ALUresult;
            wdata_q <= WriteData;
            valu_q  <= VALUresult;
            mr_q    <= MemRead;
            mw_q    <= MemWrite;
            vm_q    <= VecMem;
            rw_q    <= RegWrite;
            vrw_q   <= VRegWrite;
            rd_q    <= Rd;
            beat    <= '0;
         end
         if (state == VBEAT) begin
            beat <= beat + 2'd1;
            if (mr_q) begin
               case (beat)
                  2'd0:    vbuf[31:0]  <= mem_rdata;
                  2'd1:    vbuf[63:32] <= mem_rdata;
                  default: vbuf[95:64] <= mem_rdata;
               endcase
            end
         end
         if (done) begin
            wb_result    <= res_n;
            wb_vresult   <= vres_n;
            wb_rd        <= live ? Rd : rd_q;
            wb_regwrite  <= live ? RegWrite : rw_q;
            wb_vregwrite <= live ? VRegWrite : vrw_q;
         end
      end
   end

endmodule
